tlb_set_assoc_array: RTL and testbench
======================================

Name: tlb_set_assoc_array

Overview:
- Parametrised set-associative TLB array with a registered lookup path, built-in true-LRU age tracking and victim selection, a fill port, single-entry invalidate and a multi-cycle flush-all walker.
- Sits between the TLB control FSM and the page-walk fill path.
- Supersedes the fixed 4-way storage array: geometry is configurable, and the saturating LRU counters become a rank-based LRU with a victim output.

Parameters:
- NUM_SETS, 16, number of sets (power of 2, ≥2)
- NUM_WAYS, 4, ways per set (power of 2, ≥2)
- VPN_BITS, 20, virtual page number width (full VPN stored as tag)
- PPN_BITS, 20, physical page number width
- PERM_BITS, 2, permission field width
- SET_BITS, $clog2(NUM_SETS), derived, not overridden
- WAY_BITS, $clog2(NUM_WAYS), derived, also the width of each age field

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lk_req  in  1  lookup request
- lk_vpn  in  VPN_BITS  lookup VPN; set index = lk_vpn[SET_BITS-1:0]
- lk_ready  out  1  lookup accepted when lk_req && lk_ready
- lk_rsp_valid  out  1  response strobe, 1 cycle after acceptance
- lk_hit  out  1  valid entry with matching VPN found
- lk_way  out  WAY_BITS  hit way (0 on miss)
- lk_ppn  out  PPN_BITS  hit PPN (0 on miss)
- lk_perms  out  PERM_BITS  hit perms (0 on miss)
- lk_victim_way  out  WAY_BITS  replacement way for the looked-up set
- fill_en  in  1  write entry
- fill_vpn  in  VPN_BITS  VPN to write; set derived as for lookup
- fill_way  in  WAY_BITS  target way
- fill_ppn  in  PPN_BITS  PPN to write
- fill_perms  in  PERM_BITS  perms to write
- inv_en  in  1  invalidate matching entry
- inv_vpn  in  VPN_BITS  VPN to invalidate
- flush_req  in  1  start flush-all
- flush_busy  out  1  flush walk in progress
- flush_done  out  1  one-cycle pulse on the final flush cycle

Behaviour:
- Storage: per set and way, hold valid, vpn, ppn, perms and age[WAY_BITS]. Within a set, ages always form a permutation of 0..NUM_WAYS-1. Age 0 = MRU, NUM_WAYS-1 = LRU.
- Reset:
  - All valid bits = 0.
  - age[s][w] = w.
  - Outputs: lk_rsp_valid=0, lk_hit=0, lk_way=0, lk_ppn=0, lk_perms=0, lk_victim_way=0, flush_busy=0, flush_done=0.
  - lk_ready=1 in the first cycle after reset.
  - Reset mid-flush aborts the walk, FSM returns to IDLE.
- Lookup:
  - Compare all ways of the set combinationally; register the results. Latency is 1 cycle.
  - Multiple matches: lowest way index wins.
  - Miss drives lk_way, lk_ppn and lk_perms to 0.
  - lk_victim_way = lowest-index invalid way; if none, the way with age NUM_WAYS-1. Computed from pre-update state and registered with the response.
  - Output registers hold their value when no lookup is accepted. lk_rsp_valid is 0 in those cycles.
- LRU touch of way w with old age a, applied on lookup hit or fill:
  - Ways with age < a increment.
  - w becomes 0.
  - Other ages are unchanged.
- Fill: writes valid=1, vpn, ppn and perms at set(fill_vpn), way fill_way, and touches fill_way. Fill is ignored while flush_busy=1.
- Invalidate:
  - Clears valid of every way in set(inv_vpn) with matching vpn. Ages are unchanged.
  - Ignored while flush_busy=1.
- Same-cycle priority within one set:
  - Update priority is fill > invalidate > lookup-hit touch. A lookup-hit touch is dropped when a fill or invalidate targets the same set in that cycle.
  - Operations on different sets proceed in parallel.
  - A lookup always sees pre-write contents (read-before-write).
- Flush FSM:
  - IDLE: flush_req=1 → WALK, ptr=0, flush_busy=1 from the next cycle.
  - WALK: clear valid of all ways in set ptr. Ages are unchanged. ptr increments each cycle.
  - When ptr=NUM_SETS-1: flush_done=1 that cycle, then → IDLE.
  - Total NUM_SETS busy cycles.
  - flush_req while busy is ignored.
- lk_ready = !flush_busy (combinational).
  - A lookup accepted in the flush_req cycle completes against pre-flush contents.
  - lk_req while busy is not accepted; the requester holds the request.

Test Plan:
- Reset, then lookup 0x00012 → lk_rsp_valid=1 one cycle later, lk_hit=0, lk_victim_way=0.
- Fill vpn 0x00012 ppn 0xABCDE perms 2'b11 way 2 (NUM_SETS=16 → set 2), then lookup 0x00012 → hit, way=2, ppn=0xABCDE, perms=3.
- Fill ways 0..3 of set 5 in order 0,1,2,3, hit way 1, lookup a missing vpn in set 5 → lk_victim_way=0. Hit way 0 → next miss gives victim 2.
- Same cycle: lookup hit on set 5 way 3 and fill of set 5 way 0 → lookup returns old way-3 data. Way 0 age=0 and way 3 age unchanged from before.
- Invalidate a present vpn, then lookup it → miss; that way becomes lk_victim_way.
- flush_req with entries valid, lk_req held → flush_busy high 16 cycles, lk_ready=0, flush_done pulses on cycle 16. The held lookup is then accepted and misses. Repeat with rst asserted mid-walk → busy=0 next cycle.

Source files
------------

// File: rtl/tlb_set_assoc_array.sv
// Set-associative TLB storage array.
// Registered single-cycle lookup with hit data and replacement victim, true-LRU
// rank ages per set, a fill port, single-entry invalidate and a flush-all walker
// that clears one set per cycle.
module tlb_set_assoc_array #(
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4,
    parameter int VPN_BITS  = 20,
    parameter int PPN_BITS  = 20,
    parameter int PERM_BITS = 2,
    // Derived geometry; leave at their defaults.
    parameter int SET_BITS  = $clog2(NUM_SETS),
    parameter int WAY_BITS  = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 lk_req,
    input  logic [VPN_BITS-1:0]  lk_vpn,
    output logic                 lk_ready,
    output logic                 lk_rsp_valid,
    output logic                 lk_hit,
    output logic [WAY_BITS-1:0]  lk_way,
    output logic [PPN_BITS-1:0]  lk_ppn,
    output logic [PERM_BITS-1:0] lk_perms,
    output logic [WAY_BITS-1:0]  lk_victim_way,

    input  logic                 fill_en,
    input  logic [VPN_BITS-1:0]  fill_vpn,
    input  logic [WAY_BITS-1:0]  fill_way,
    input  logic [PPN_BITS-1:0]  fill_ppn,
    input  logic [PERM_BITS-1:0] fill_perms,

    input  logic                 inv_en,
    input  logic [VPN_BITS-1:0]  inv_vpn,

    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done
);

    localparam logic [WAY_BITS-1:0] AGE_LRU  = WAY_BITS'(NUM_WAYS - 1);
    localparam logic [WAY_BITS-1:0] AGE_ONE  = WAY_BITS'(1);
    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);
    localparam logic [SET_BITS-1:0] SET_ONE  = SET_BITS'(1);

    typedef enum logic {
        ST_IDLE,
        ST_WALK
    } flush_state_e;

    // Entry storage. Only valid and age carry reset state.
    logic [NUM_WAYS-1:0]  valid_q   [NUM_SETS];
    logic [WAY_BITS-1:0]  age_q     [NUM_SETS][NUM_WAYS];
    logic [VPN_BITS-1:0]  vpn_mem   [NUM_SETS][NUM_WAYS];
    logic [PPN_BITS-1:0]  ppn_mem   [NUM_SETS][NUM_WAYS];
    logic [PERM_BITS-1:0] perms_mem [NUM_SETS][NUM_WAYS];

    flush_state_e         state_q;
    logic [SET_BITS-1:0]  ptr_q;

    logic [SET_BITS-1:0]  lk_set;
    logic [SET_BITS-1:0]  fill_set;
    logic [SET_BITS-1:0]  inv_set;

    logic                 lk_acc;
    logic                 fill_act;
    logic                 inv_any;
    logic                 inv_act;
    logic                 touch_act;
    logic                 walking;

    logic                 hit_c;
    logic [WAY_BITS-1:0]  way_c;
    logic [PPN_BITS-1:0]  ppn_c;
    logic [PERM_BITS-1:0] perms_c;
    logic [WAY_BITS-1:0]  victim_c;
    logic [NUM_WAYS-1:0]  inv_match;

    logic [WAY_BITS-1:0]  fill_pivot;
    logic [WAY_BITS-1:0]  lk_pivot;

    assign lk_set   = lk_vpn[SET_BITS-1:0];
    assign fill_set = fill_vpn[SET_BITS-1:0];
    assign inv_set  = inv_vpn[SET_BITS-1:0];

    assign walking  = (state_q == ST_WALK);
    assign lk_ready = !flush_busy;
    assign lk_acc   = lk_req && lk_ready;

    // Fill beats invalidate in the same set; either one suppresses a lookup touch
    // of that set so the LRU ranks stay a permutation.
    assign fill_act  = fill_en && !flush_busy;
    assign inv_any   = inv_en && !flush_busy;
    assign inv_act   = inv_any && !(fill_act && (fill_set == inv_set));
    assign touch_act = lk_acc && hit_c
                     && !(fill_act && (fill_set == lk_set))
                     && !(inv_any && (inv_set == lk_set));

    assign fill_pivot = age_q[fill_set][fill_way];
    assign lk_pivot   = age_q[lk_set][way_c];

    // New age of one way when the way owning rank 'pivot' becomes MRU.
    function automatic logic [WAY_BITS-1:0] touched_age(
        input logic [WAY_BITS-1:0] cur,
        input logic [WAY_BITS-1:0] pivot,
        input logic                is_target
    );
        if (is_target)        return '0;
        else if (cur < pivot) return cur + AGE_ONE;
        else                  return cur;
    endfunction

    // Tag compare, hit select (lowest way wins) and victim choice for the lookup set.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        hit_c    = 1'b0;
        way_c    = '0;
        ppn_c    = '0;
        perms_c  = '0;
        victim_c = '0;
        // Descending scans let the lowest matching index overwrite the others.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (age_q[lk_set][w] == AGE_LRU) victim_c = WAY_BITS'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[lk_set][w]) victim_c = WAY_BITS'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_set][w] && (vpn_mem[lk_set][w] == lk_vpn)) begin
                hit_c   = 1'b1;
                way_c   = WAY_BITS'(w);
                ppn_c   = ppn_mem[lk_set][w];
                perms_c = perms_mem[lk_set][w];
            end
        end
    end

    // Ways of the invalidate set whose stored VPN matches.
    always_comb begin
        inv_match = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            inv_match[w] = valid_q[inv_set][w] && (vpn_mem[inv_set][w] == inv_vpn);
        end
    end

    // Valid bits and LRU ranks: flush walk, fill, invalidate and lookup touch.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every read in
        // this cycle sees the pre-edge value regardless of statement order.
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_BITS'(w);
                end
            end
        end else begin
            if (walking) valid_q[ptr_q] <= '0;
            if (fill_act) valid_q[fill_set][fill_way] <= 1'b1;
            if (inv_act) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (inv_match[w]) valid_q[inv_set][w] <= 1'b0;
                end
            end
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (fill_act) begin
                    age_q[fill_set][w] <= touched_age(age_q[fill_set][w], fill_pivot,
                                                      fill_way == WAY_BITS'(w));
                end
                if (touch_act) begin
                    age_q[lk_set][w] <= touched_age(age_q[lk_set][w], lk_pivot,
                                                    way_c == WAY_BITS'(w));
                end
            end
        end
    end

    // Entry payload written on fill.
    always_ff @(posedge clk) begin
        // NOTE: payload arrays are not reset; a valid bit guards every read, so
        // clearing them would only cost reset fan-out.
        if (fill_act) begin
            vpn_mem[fill_set][fill_way]   <= fill_vpn;
            ppn_mem[fill_set][fill_way]   <= fill_ppn;
            perms_mem[fill_set][fill_way] <= fill_perms;
        end
    end

    // Lookup response registers; data holds between accepted lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            lk_rsp_valid  <= 1'b0;
            lk_hit        <= 1'b0;
            lk_way        <= '0;
            lk_ppn        <= '0;
            lk_perms      <= '0;
            lk_victim_way <= '0;
        end else if (lk_acc) begin
            lk_rsp_valid  <= 1'b1;
            lk_hit        <= hit_c;
            lk_way        <= way_c;
            lk_ppn        <= ppn_c;
            lk_perms      <= perms_c;
            lk_victim_way <= victim_c;
        end else begin
            lk_rsp_valid  <= 1'b0;
        end
    end

    // Flush walker: one set per cycle, done pulse on the last set.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    flush_done <= 1'b0;
                    if (flush_req) begin
                        state_q    <= ST_WALK;
                        ptr_q      <= '0;
                        flush_busy <= 1'b1;
                    end
                end
                ST_WALK: begin
                    if (ptr_q == LAST_SET) begin
                        state_q    <= ST_IDLE;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b0;
                    end else begin
                        ptr_q      <= ptr_q + SET_ONE;
                        flush_done <= ((ptr_q + SET_ONE) == LAST_SET);
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    flush_busy <= 1'b0;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_set_assoc_array.sv
// Self-checking bench for tlb_set_assoc_array (16 sets x 4 ways).
// A vector table drives one cycle per record; lookup expectations go into a
// scoreboard queue and are compared when the response strobe appears.
module tb_tlb_set_assoc_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        lk_req;
    logic [19:0] lk_vpn;
    logic        lk_ready;
    logic        lk_rsp_valid;
    logic        lk_hit;
    logic [1:0]  lk_way;
    logic [19:0] lk_ppn;
    logic [1:0]  lk_perms;
    logic [1:0]  lk_victim_way;
    logic        fill_en;
    logic [19:0] fill_vpn;
    logic [1:0]  fill_way;
    logic [19:0] fill_ppn;
    logic [1:0]  fill_perms;
    logic        inv_en;
    logic [19:0] inv_vpn;
    logic        flush_req;
    logic        flush_busy;
    logic        flush_done;

    tlb_set_assoc_array dut (
        .clk           (clk),
        .rst           (rst),
        .lk_req        (lk_req),
        .lk_vpn        (lk_vpn),
        .lk_ready      (lk_ready),
        .lk_rsp_valid  (lk_rsp_valid),
        .lk_hit        (lk_hit),
        .lk_way        (lk_way),
        .lk_ppn        (lk_ppn),
        .lk_perms      (lk_perms),
        .lk_victim_way (lk_victim_way),
        .fill_en       (fill_en),
        .fill_vpn      (fill_vpn),
        .fill_way      (fill_way),
        .fill_ppn      (fill_ppn),
        .fill_perms    (fill_perms),
        .inv_en        (inv_en),
        .inv_vpn       (inv_vpn),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .flush_done    (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        hit;
        logic [1:0]  way;
        logic [19:0] ppn;
        logic [1:0]  perms;
        logic [1:0]  victim;
        int          due;
    } exp_t;

    typedef struct {
        string       tag;
        logic        lk;
        logic [19:0] lk_vpn;
        logic        fill;
        logic [19:0] f_vpn;
        logic [1:0]  f_way;
        logic [19:0] f_ppn;
        logic [1:0]  f_perms;
        logic        inv;
        logic [19:0] i_vpn;
        logic        e_hit;
        logic [1:0]  e_way;
        logic [19:0] e_ppn;
        logic [1:0]  e_perms;
        logic [1:0]  e_victim;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];
    vec_t vecs[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic hit, input logic [1:0] way,
                            input logic [19:0] ppn, input logic [1:0] perms,
                            input logic [1:0] victim);
        exp_t e;
        e.tag = tag; e.hit = hit; e.way = way; e.ppn = ppn;
        e.perms = perms; e.victim = victim; e.due = cyc + 1;
        sb.push_back(e);
    endtask

    // Response monitor: compares each strobe against the oldest expectation.
    always @(negedge clk) begin
        if (lk_rsp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: lk_rsp_valid=1 with no lookup outstanding");
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_latency"}, cyc, mon_e.due);
                check({mon_e.tag, "_hit"}, lk_hit, mon_e.hit);
                check({mon_e.tag, "_way"}, lk_way, mon_e.way);
                check({mon_e.tag, "_ppn"}, lk_ppn, mon_e.ppn);
                check({mon_e.tag, "_perms"}, lk_perms, mon_e.perms);
                check({mon_e.tag, "_victim"}, lk_victim_way, mon_e.victim);
            end
        end
    end

    function automatic vec_t v_nop();
        vec_t v;
        v.tag = "nop"; v.lk = 0; v.lk_vpn = '0;
        v.fill = 0; v.f_vpn = '0; v.f_way = '0; v.f_ppn = '0; v.f_perms = '0;
        v.inv = 0; v.i_vpn = '0;
        v.e_hit = 0; v.e_way = '0; v.e_ppn = '0; v.e_perms = '0; v.e_victim = '0;
        return v;
    endfunction

    function automatic vec_t v_lk(input string tag, input logic [19:0] vpn, input logic hit,
                                  input logic [1:0] way, input logic [19:0] ppn,
                                  input logic [1:0] perms, input logic [1:0] victim);
        vec_t v = v_nop();
        v.tag = tag; v.lk = 1; v.lk_vpn = vpn;
        v.e_hit = hit; v.e_way = way; v.e_ppn = ppn; v.e_perms = perms; v.e_victim = victim;
        return v;
    endfunction

    function automatic vec_t with_fill(input vec_t vi, input logic [19:0] vpn, input logic [1:0] way,
                                       input logic [19:0] ppn, input logic [1:0] perms);
        vec_t v = vi;
        v.fill = 1; v.f_vpn = vpn; v.f_way = way; v.f_ppn = ppn; v.f_perms = perms;
        return v;
    endfunction

    function automatic vec_t with_inv(input vec_t vi, input logic [19:0] vpn);
        vec_t v = vi;
        v.inv = 1; v.i_vpn = vpn;
        return v;
    endfunction

    task automatic idle_inputs();
        lk_req = 0; lk_vpn = '0;
        fill_en = 0; fill_vpn = '0; fill_way = '0; fill_ppn = '0; fill_perms = '0;
        inv_en = 0; inv_vpn = '0; flush_req = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        lk_req = v.lk; lk_vpn = v.lk_vpn;
        fill_en = v.fill; fill_vpn = v.f_vpn; fill_way = v.f_way;
        fill_ppn = v.f_ppn; fill_perms = v.f_perms;
        inv_en = v.inv; inv_vpn = v.i_vpn;
        if (v.lk) push_exp(v.tag, v.e_hit, v.e_way, v.e_ppn, v.e_perms, v.e_victim);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;

        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rsp_valid", lk_rsp_valid, 0);
        check("rst_hit", lk_hit, 0);
        check("rst_way", lk_way, 0);
        check("rst_ppn", lk_ppn, 0);
        check("rst_perms", lk_perms, 0);
        check("rst_victim", lk_victim_way, 0);
        check("rst_flush_busy", flush_busy, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_lk_ready", lk_ready, 1);
        rst = 1'b0;

        // Set 5 holds A=00105 B=00205 C=00305 D=00405 in ways 0..3; ranks noted per step.
        vecs.push_back(v_lk("lk_cold", 20'h00012, 0, 0, 0, 0, 0));
        vecs.push_back(with_fill(v_nop(), 20'h00012, 2, 20'hABCDE, 2'b11));
        vecs.push_back(v_lk("lk_fill_hit", 20'h00012, 1, 2, 20'hABCDE, 3, 0));
        vecs.push_back(with_fill(v_nop(), 20'h00105, 0, 20'h11111, 1));
        vecs.push_back(with_fill(v_nop(), 20'h00205, 1, 20'h22222, 2));
        vecs.push_back(with_fill(v_nop(), 20'h00305, 2, 20'h33333, 3));
        vecs.push_back(with_fill(v_nop(), 20'h00405, 3, 20'h44444, 0));
        // ages [3,2,1,0]
        vecs.push_back(v_lk("lru_hit_b", 20'h00205, 1, 1, 20'h22222, 2, 0));
        // ages [3,0,2,1]
        vecs.push_back(v_lk("lru_miss1", 20'h00505, 0, 0, 0, 0, 0));
        vecs.push_back(v_lk("lru_hit_a", 20'h00105, 1, 0, 20'h11111, 1, 0));
        // ages [0,1,3,2]
        vecs.push_back(v_lk("lru_miss2", 20'h00505, 0, 0, 0, 0, 2));
        // Same set: fill way 0 wins, lookup of way 3 sees old data and its touch is dropped.
        vecs.push_back(with_fill(v_lk("rbw_same", 20'h00405, 1, 3, 20'h44444, 0, 2),
                                 20'h00605, 0, 20'h55555, 1));
        // ages [0,1,3,2]
        vecs.push_back(v_lk("hit_c", 20'h00305, 1, 2, 20'h33333, 3, 2));
        // ages [1,2,0,3]
        vecs.push_back(v_lk("touch_drop", 20'h00505, 0, 0, 0, 0, 3));
        vecs.push_back(v_lk("hit_e", 20'h00605, 1, 0, 20'h55555, 1, 3));
        // ages [0,2,1,3]
        vecs.push_back(v_lk("a_replaced", 20'h00105, 0, 0, 0, 0, 3));
        vecs.push_back(with_inv(v_nop(), 20'h00205));
        vecs.push_back(v_lk("inv_victim", 20'h00205, 0, 0, 0, 0, 1));
        vecs.push_back(with_inv(v_lk("inv_rbw", 20'h00305, 1, 2, 20'h33333, 3, 1), 20'h00305));
        vecs.push_back(v_lk("inv_after", 20'h00305, 0, 0, 0, 0, 1));
        // Different sets update in parallel.
        vecs.push_back(with_fill(v_lk("par_sets", 20'h00012, 1, 2, 20'hABCDE, 3, 0),
                                 20'h00107, 1, 20'h77777, 2));
        vecs.push_back(v_lk("par_fill", 20'h00107, 1, 1, 20'h77777, 2, 0));
        // Duplicate VPN in two ways: the lower way wins.
        vecs.push_back(with_fill(v_nop(), 20'h00009, 3, 20'h99993, 1));
        vecs.push_back(with_fill(v_nop(), 20'h00009, 1, 20'h99991, 2));
        vecs.push_back(v_lk("multi_match", 20'h00009, 1, 1, 20'h99991, 2, 0));
        vecs.push_back(with_inv(v_nop(), 20'h00009));
        vecs.push_back(v_lk("multi_inv", 20'h00009, 0, 0, 0, 0, 0));

        foreach (vecs[i]) drive_vec(vecs[i]);

        // Flush with a lookup in the request cycle, then a held lookup during the walk.
        flush_req = 1; lk_req = 1; lk_vpn = 20'h00012;
        push_exp("flush_pre", 1, 2, 20'hABCDE, 3, 0);
        @(negedge clk);
        flush_req = 0;
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int i = 0; i < 40 && flush_busy; i++) begin
            busy_cnt++;
            check("ready_low_busy", lk_ready, 0);
            if (flush_done) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            // Fill into an already-walked set must be ignored.
            fill_en = (busy_cnt == 3); fill_vpn = 20'h00000; fill_way = 0;
            fill_ppn = 20'hFFFFF; fill_perms = 3;
            @(negedge clk);
        end
        fill_en = 0;
        check("flush_busy_cycles", busy_cnt, 16);
        check("flush_done_count", done_cnt, 1);
        check("flush_done_cycle", done_at, 16);
        check("ready_after_flush", lk_ready, 1);
        if (lk_ready) push_exp("flush_held", 0, 0, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        drive_vec(v_lk("fill_ignored", 20'h00000, 0, 0, 0, 0, 0));
        drive_vec(v_lk("flushed_set7", 20'h00107, 0, 0, 0, 0, 0));

        // Reset in the middle of a walk aborts it.
        flush_req = 1;
        @(negedge clk);
        flush_req = 0;
        repeat (4) @(negedge clk);
        check("flush2_busy", flush_busy, 1);
        rst = 1;
        @(negedge clk);
        check("rst_abort_busy", flush_busy, 0);
        check("rst_abort_done", flush_done, 0);
        check("rst_abort_ready", lk_ready, 1);
        rst = 0;
        drive_vec(v_lk("post_rst", 20'h00012, 0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
